// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the 10-bit PISO serializer
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic SOUT_IDLE     = 1'b0;
  localparam int   DEFAULT_WIDTH = 10;

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - bit-position counter with clear, increment and terminal flag
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(WIDTH - 1));

  // Saturates at the terminal count so the index never wraps past the last bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer_10b.sv
// rtl/piso_serializer_10b.sv - parallel-in/serial-out transmitter, optional PISO_PARITY_EN trailer bit
module piso_serializer_10b
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] din_sh;
  logic             dir_sh;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [CNT_W-1:0] sel;
  logic             last_bit;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             next_bit;

  assign cnt_clr = (state == IDLE) && load;
  assign cnt_inc = (state == SHIFT) && enable;

  piso_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(cnt_inc),
    .cnt(cnt),
    .tc (last_bit)
  );

  // Shadow word stays intact so the parity trailer can be taken over all bits.
  always_comb begin
    nxt_cnt  = cnt + CNT_W'(1);
    sel      = dir_sh ? (CNT_W'(WIDTH - 1) - nxt_cnt) : nxt_cnt;
    next_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == CNT_W'(i)) next_bit = din_sh[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sout   <= SOUT_IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      din_sh <= '0;
      dir_sh <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            din_sh <= din;
            dir_sh <= dir;
            sout   <= dir ? din[WIDTH-1] : din[0];
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            if (last_bit) begin
`ifdef PISO_PARITY_EN
              sout  <= ^din_sh;
              state <= PARITY;
`else
              sout  <= SOUT_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`endif
            end else begin
              sout <= next_bit;
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (enable) begin
            sout  <= SOUT_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          sout  <= SOUT_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer_10b.sv
// tb/tb_piso_serializer_10b.sv - self-checking bench for piso_serializer_10b
module tb_piso_serializer_10b;

  localparam int W = 10;
`ifdef PISO_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] din = '0;
  logic         sout, ready, busy, done;

  int errors = 0;
  int checks = 0;

  piso_serializer_10b dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .dir(dir),
    .din(din), .sout(sout), .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit k as the link sees it: data in the requested order, then even parity.
  function automatic logic model_bit(input logic [W-1:0] d, input logic dr, input int k);
    if (k >= W) return ^d;
    return dr ? d[W-1-k] : d[k];
  endfunction

  task automatic send_frame(input logic [W-1:0] d, input logic dr, input int period,
                            input bit le, input bit lockout);
    logic [W-1:0] rx;
    rx = '0;
    for (int i = 0; i < 40 && !ready; i++) tick();
    check("ready_before_load", ready, 1'b1);
    din = d; dir = dr; load = 1'b1; enable = le;
    tick();
    load = 1'b0; enable = 1'b0;
    din = W'($urandom); dir = ~dr;
    check("ready_after_load", ready, 1'b0);
    check("busy_after_load", busy, 1'b1);
    for (int k = 0; k < NBITS; k++) begin
      for (int p = 0; p < period; p++) begin
        check($sformatf("sout_bit%0d", k), sout, model_bit(d, dr, k));
        if (p == 0) check($sformatf("done_low_bit%0d", k), done, 1'b0);
        enable = (p == period - 1);
        if (lockout && k == 3 && p == 0) begin
          load = 1'b1; din = 10'h0AA;
        end
        if (enable && k < W) rx = dr ? {rx[W-2:0], sout} : {sout, rx[W-1:1]};
        tick();
        load = 1'b0; enable = 1'b0;
      end
    end
    check("done_pulse", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    check("ready_in_done", ready, 1'b0);
    check("sout_idle_done", sout, 1'b0);
    if (lockout) begin
      load = 1'b1; din = 10'h0AA;
    end
    tick();
    load = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", ready, 1'b1);
    check("busy_after_done", busy, 1'b0);
    check("rx_word", rx, d);
    if (lockout) begin
      tick();
      check("load_in_done_ignored", busy, 1'b0);
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_sout", sout, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Reset in the middle of a frame.
    din = 10'h3FF; dir = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1;
      tick();
    end
    enable = 1'b0;
    check("midframe_sout_high", sout, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sout", sout, 1'b0);
    check("midrst_ready", ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);

    send_frame(10'b1011001110, 1'b1, 1, 1'b0, 1'b0);
    send_frame(10'b1011001110, 1'b0, 4, 1'b0, 1'b0);
    send_frame(10'h155, 1'b1, 2, 1'b0, 1'b1);
    send_frame(10'h001, 1'b0, 1, 1'b1, 1'b0);
    send_frame(10'h001, 1'b1, 1, 1'b0, 1'b0);
    send_frame(10'h003, 1'b0, 3, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      send_frame(W'($urandom), 1'($urandom), int'($urandom_range(1, 3)), 1'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
